// File: rtl/baud_tick_generator_if.sv
// Bus bundle for baud_tick_generator.
//   master : the controller side (CPU divisor write, RX start-bit detector, enable)
//            drives EN, SYNC, DIV_WE, DIV_IN; observes DIV_OUT and the tick strobes.
//   slave  : the baud generator itself.
// Signals:
//   EN       count enable
//   SYNC     one-cycle phase restart pulse
//   DIV_WE   divisor write strobe
//   DIV_IN   new divisor value
//   DIV_OUT  currently active divisor
//   OS_TICK  one-cycle oversample strobe
//   MID      one-cycle mid-bit strobe
//   END      one-cycle end-of-bit strobe
interface baud_tick_generator_if #(
    parameter int unsigned DIV_WIDTH = 16
);
    logic                 EN;
    logic                 SYNC;
    logic                 DIV_WE;
    logic [DIV_WIDTH-1:0] DIV_IN;
    logic [DIV_WIDTH-1:0] DIV_OUT;
    logic                 OS_TICK;
    logic                 MID;
    logic                 END;

    modport master (
        output EN,
        output SYNC,
        output DIV_WE,
        output DIV_IN,
        input  DIV_OUT,
        input  OS_TICK,
        input  MID,
        input  END
    );

    modport slave (
        input  EN,
        input  SYNC,
        input  DIV_WE,
        input  DIV_IN,
        output DIV_OUT,
        output OS_TICK,
        output MID,
        output END
    );
endinterface

// File: rtl/baud_tick_generator.sv
// Runtime-programmable baud timing source for the UART datapath.
// A prescaler (p) divides the clock by the active divisor to give the oversample
// tick; a sub-bit counter (s) counts oversample ticks to give mid-bit and end-of-bit
// strobes. All three strobes come from the same counter chain, so they stay aligned.
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous active-high reset
//   bus  slave modport of baud_tick_generator_if (enable, sync, divisor write,
//        active divisor readback, OS_TICK / MID / END strobes)
// OVERSAMPLE must be even and >= 2.
module baud_tick_generator #(
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DEFAULT_DIV = 27
) (
    input logic                  CLK,
    input logic                  RST,
    baud_tick_generator_if.slave bus
);

    localparam int unsigned SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    // A zero divisor would never reach terminal count; treat it as 1.
    localparam logic [DIV_WIDTH-1:0] DIV_RST =
        (DEFAULT_DIV == 0) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_DIV);

    logic [DIV_WIDTH-1:0] div_d, div_q;
    logic [DIV_WIDTH-1:0] p_d, p_q;
    logic [SW-1:0]        s_d, s_q;
    logic                 os_tick_d, os_tick_q;
    logic                 mid_d, mid_q;
    logic                 end_d, end_q;

    always_comb begin
        div_d     = div_q;
        p_d       = p_q;
        s_d       = s_q;
        os_tick_d = 1'b0;
        mid_d     = 1'b0;
        end_d     = 1'b0;

        if (bus.SYNC || bus.DIV_WE) begin
            // Both restart the phase; a divisor write additionally loads div.
            p_d = '0;
            s_d = '0;
            if (bus.DIV_WE) begin
                div_d = (bus.DIV_IN == '0) ? DIV_WIDTH'(1) : bus.DIV_IN;
            end
        end else if (bus.EN) begin
            if (p_q == div_q - DIV_WIDTH'(1)) begin
                p_d       = '0;
                os_tick_d = 1'b1;
                mid_d     = (s_q == S_MID);
                end_d     = (s_q == S_LAST);
                s_d       = (s_q == S_LAST) ? '0 : s_q + SW'(1);
            end else begin
                p_d = p_q + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q     <= DIV_RST;
            p_q       <= '0;
            s_q       <= '0;
            os_tick_q <= 1'b0;
            mid_q     <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            p_q       <= p_d;
            s_q       <= s_d;
            os_tick_q <= os_tick_d;
            mid_q     <= mid_d;
            end_q     <= end_d;
        end
    end

    assign bus.DIV_OUT = div_q;
    assign bus.OS_TICK = os_tick_q;
    assign bus.MID     = mid_q;
    assign bus.END     = end_q;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed self-checking bench for baud_tick_generator (OVERSAMPLE=4, DEFAULT_DIV=3).
// Tick vectors are packed as {OS_TICK, MID, END}.
module tb_baud_tick_generator;

    localparam int unsigned DW = 16;
    localparam int          OS = 4;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    baud_tick_generator_if #(.DIV_WIDTH(DW)) bus ();

    baud_tick_generator #(
        .DIV_WIDTH  (DW),
        .OVERSAMPLE (OS),
        .DEFAULT_DIV(3)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq(tag, {29'b0, bus.OS_TICK, bus.MID, bus.END}, 32'h0);
    endtask

    // Steps n edges counted from phase zero (first edge is k0+1). With divisor d,
    // OS_TICK follows edges k*d, MID follows edge d*OS/2 of each bit, END edge d*OS.
    task automatic run_sched(input string tag, input int d, input int k0, input int n);
        int   k;
        logic [2:0] exp;
        for (int i = 1; i <= n; i++) begin
            k = k0 + i;
            step();
            exp = {(k % d) == 0, (k % (OS * d)) == (OS / 2) * d, (k % (OS * d)) == 0};
            check_eq($sformatf("%s_e%0d", tag, k),
                     {29'b0, bus.OS_TICK, bus.MID, bus.END}, {29'b0, exp});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.EN     = 1'b1;
        bus.SYNC   = 1'b0;
        bus.DIV_WE = 1'b0;
        bus.DIV_IN = '0;
        repeat (2) step();

        // Reset state
        check_quiet("rst_ticks");
        check_eq("rst_div", 32'(bus.DIV_OUT), 32'd3);
        rst = 1'b0;

        // Default schedule from reset release
        run_sched("t1", 3, 0, 24);
        check_eq("t1_div", 32'(bus.DIV_OUT), 32'd3);

        // Divisor write of 5 on edge 7
        do_reset();
        run_sched("t2pre", 3, 0, 6);
        bus.DIV_IN = 16'd5;
        bus.DIV_WE = 1'b1;
        step();
        bus.DIV_WE = 1'b0;
        check_quiet("t2_we_ticks");
        check_eq("t2_div", 32'(bus.DIV_OUT), 32'd5);
        run_sched("t2", 5, 0, 24);

        // Zero divisor clamps to 1; the write lands on an edge where OS_TICK was due
        bus.DIV_IN = 16'd0;
        bus.DIV_WE = 1'b1;
        step();
        bus.DIV_WE = 1'b0;
        check_quiet("t3_we_ticks");
        check_eq("t3_div", 32'(bus.DIV_OUT), 32'd1);
        run_sched("t3", 1, 0, 8);

        // Asynchronous reset while END is high
        check_eq("t6_pre_end", 32'(bus.END), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_quiet("t6_async_ticks");
        check_eq("t6_async_div", 32'(bus.DIV_OUT), 32'd3);
        step();
        check_quiet("t6_hold1");
        step();
        check_quiet("t6_hold2");
        rst = 1'b0;
        run_sched("t6", 3, 0, 24);

        // SYNC with s=2, p=1
        run_sched("t4pre", 3, 24, 7);
        bus.SYNC = 1'b1;
        step();
        bus.SYNC = 1'b0;
        check_quiet("t4_sync_ticks");
        run_sched("t4", 3, 0, 12);

        // EN low for 7 cycles mid-bit
        run_sched("t5pre", 3, 0, 7);
        bus.EN = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check_quiet($sformatf("t5_hold%0d", i));
        end
        bus.EN = 1'b1;
        run_sched("t5", 3, 7, 17);

        // SYNC and DIV_WE together on an edge where OS_TICK was due
        run_sched("t7pre", 3, 0, 2);
        bus.DIV_IN = 16'd2;
        bus.DIV_WE = 1'b1;
        bus.SYNC   = 1'b1;
        step();
        bus.DIV_WE = 1'b0;
        bus.SYNC   = 1'b0;
        check_quiet("t7_ticks");
        check_eq("t7_div", 32'(bus.DIV_OUT), 32'd2);
        run_sched("t7", 2, 0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/baud_tick_generator.md
# baud_tick_generator

Parametrised, runtime-programmable baud timing source for the UART datapath of the RISC-V CPU. It supersedes the fixed-rate baud generator. A single instance produces three aligned strobes from one phase-coherent counter chain: an oversample tick, a mid-bit tick and an end-of-bit tick. The instance also accepts a divisor written by the CPU and a phase-restart request from the receiver's start-bit detector.

## Interface
Parameters:
- DIV_WIDTH, 16: width of the prescale divisor and prescale counter.
- OVERSAMPLE, 16: oversample ticks per bit. Must be even and ≥ 2.
- DEFAULT_DIV, 27: divisor loaded at reset (50 MHz / (115200·16) ≈ 27).

Ports (one clock; reset is asynchronous and active-high):
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- EN  input  1  count enable. When low, counters hold and no ticks are issued.
- SYNC  input  1  phase restart; one-cycle pulse from the RX start-bit detector.
- DIV_WE  input  1  divisor write strobe.
- DIV_IN  input  DIV_WIDTH  new divisor value.
- DIV_OUT  output  DIV_WIDTH  currently active divisor.
- OS_TICK  output  1  one-cycle oversample strobe.
- MID  output  1  one-cycle strobe at the middle of each bit.
- END  output  1  one-cycle strobe at the end of each bit.

## Operation
- Internal state:
  - div_reg (DIV_WIDTH).
  - Prescale counter p (DIV_WIDTH).
  - Sub-bit counter s (width $clog2(OVERSAMPLE)).
  - Registered OS_TICK, MID, END.
- Reset (async, RST=1):
  - p=0, s=0.
  - OS_TICK=MID=END=0.
  - div_reg=DEFAULT_DIV, so DIV_OUT=DEFAULT_DIV.
- Divisor write: on an edge with DIV_WE=1, div_reg ← DIV_IN. DIV_IN=0 is clamped to 1. The write also forces p=0, s=0 and all ticks 0 on that edge. The write is honoured regardless of EN.
- SYNC: on an edge with SYNC=1, p=0, s=0 and all ticks 0. It is honoured regardless of EN.
- SYNC and DIV_WE in the same cycle: both take effect, giving a new divisor with phase zero.
- Priority per edge: RST > (SYNC | DIV_WE) > EN=0 (hold, ticks 0) > normal count.
- Normal count (EN=1, no SYNC or DIV_WE):
  - If p == div_reg−1:
    - p ← 0.
    - OS_TICK ← 1.
    - MID ← (s == OVERSAMPLE/2−1).
    - END ← (s == OVERSAMPLE−1).
    - s ← (s == OVERSAMPLE−1) ? 0 : s+1.
  - Otherwise p ← p+1 and all ticks ← 0.
- Consequences:
  - MID and END are always coincident with an OS_TICK.
  - MID and END are never high together.
- Wrap-around: s wraps from OVERSAMPLE−1 to 0 on the END tick. p wraps to 0 on every OS_TICK.
- div_reg=1: OS_TICK is high on every enabled cycle. MID/END still occur every OVERSAMPLE cycles.

## Timing
- All outputs are registered. Each tick is high for exactly one cycle, the cycle after the terminal-count edge.
- Phase zero is defined as RST release, or the edge that applied SYNC/DIV_WE. Counting from phase zero with EN held high, edges are numbered 1, 2, …:
  - OS_TICK is high after edges k·D (D = div_reg).
  - MID is high after edge D·OVERSAMPLE/2.
  - END is high after edge D·OVERSAMPLE.
  - The bit period is D·OVERSAMPLE cycles.
- EN low for N cycles stretches every subsequent tick by exactly N cycles. Phase is preserved.
- DIV_OUT updates the cycle after the DIV_WE edge.
- RST asserted mid-bit clears all outputs immediately (asynchronous). Counting restarts from phase zero at release.

## Test plan
Bench parameters: OVERSAMPLE=4, DEFAULT_DIV=3, EN=1 unless stated.
- Reset then run 24 cycles -> DIV_OUT=3; OS_TICK after edges 3, 6, 9, 12, …; MID after edges 6 and 18; END after edges 12 and 24.
- DIV_IN=5 with DIV_WE pulse at cycle 7 -> DIV_OUT=5 next cycle; all ticks 0 on the write edge; next OS_TICK 5 edges later; END 20 edges after the write.
- DIV_IN=0 written -> DIV_OUT=1; OS_TICK high every cycle; END every 4th cycle.
- SYNC pulse at s=2, p=1 -> ticks 0; next MID 6 edges later; next END 12 edges later.
- EN low for 7 cycles mid-bit -> no ticks while low; next END exactly 7 cycles later than the unpaused schedule.
- RST asserted for 2 cycles with END pending -> outputs 0 asynchronously; DIV_OUT=3 after reset; schedule restarts from release.
